// File: rtl/bcd_serial_converter.sv
// rtl/bcd_serial_converter.sv - sequential double-dabble binary-to-BCD converter
//
// Converts a WIDTH-bit binary value into four BCD digits, one input bit per
// clock, with a start/done handshake. Results are registered and held
// between conversions, so the display never sees intermediate values.
//
// Optional feature macro: BCD_BLANK_EN
//   defined   - leading-zero blank mask is computed and registered with bcd
//   undefined - blank logic is not built and blank is tied to 4'b0000
//
// Parameters:
//   WIDTH  binary input width, 1..13 (2^WIDTH-1 must fit in four digits)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   conversion request, sampled only when idle
//   num    in   binary value, captured on the accepting edge
//   busy   out  high while a conversion is in progress
//   done   out  one-cycle pulse when bcd/blank update
//   bcd    out  {thousands, hundreds, tens, ones}
//   blank  out  leading-zero blank mask, same digit order as bcd

module bcd_serial_converter #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic [3:0]       blank
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_shift;
    logic [15:0]      r_scratch;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [15:0]      r_bcd;

    logic             w_last;
    logic [15:0]      w_adj;
    logic [15:0]      w_scratch_next;
    logic [WIDTH-1:0] w_shift_next;

    assign w_last = (r_cnt == CW'(1));

    // Digit correction followed by the one-bit shift. Scratch bit 15 never
    // carries anything for legal WIDTH, so shifting it out is harmless.
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            else
                w_adj[4*i +: 4] = r_scratch[4*i +: 4];
        end
        w_scratch_next = (w_adj << 1) | 16'(r_shift[WIDTH-1]);
        w_shift_next   = r_shift << 1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next_state = S_SHIFT;
            S_SHIFT: if (w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (r_state == S_SHIFT);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= num;
                        r_scratch <= '0;
                        r_cnt     <= CW'(WIDTH);
                    end
                end
                S_SHIFT: begin
                    r_shift   <= w_shift_next;
                    r_scratch <= w_scratch_next;
                    r_cnt     <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_bcd  <= w_scratch_next;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

`ifdef BCD_BLANK_EN
    logic [3:0] r_blank;
    logic [3:0] w_blank;

    // Blanking ripples down from the thousands digit; ones is always shown.
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = (w_scratch_next[15:12] == 4'd0);
        w_blank[2] = w_blank[3] & (w_scratch_next[11:8] == 4'd0);
        w_blank[1] = w_blank[2] & (w_scratch_next[7:4] == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_blank <= 4'b0000;
        else if (r_state == S_SHIFT && w_last)
            r_blank <= w_blank;
    end

    assign blank = r_blank;
`else
    assign blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bcd_serial_converter.sv
// tb/tb_bcd_serial_converter.sv - self-checking bench for bcd_serial_converter

module tb_bcd_serial_converter;

`ifdef BCD_BLANK_EN
    localparam logic [3:0] BMASK = 4'b1111;
`else
    localparam logic [3:0] BMASK = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] num;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [3:0]  blank;

    logic        start4;
    logic [3:0]  num4;
    logic        busy4;
    logic        done4;
    logic [15:0] bcd4;
    logic [3:0]  blank4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_serial_converter #(.WIDTH(13)) dut (
        .clk(clk), .rst(rst), .start(start), .num(num),
        .busy(busy), .done(done), .bcd(bcd), .blank(blank)
    );

    bcd_serial_converter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .num(num4),
        .busy(busy4), .done(done4), .bcd(bcd4), .blank(blank4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by plain arithmetic
    function automatic logic [15:0] model_bcd(input int n);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((n / 1000) % 10);
        d2 = 4'((n / 100) % 10);
        d1 = 4'((n / 10) % 10);
        d0 = 4'(n % 10);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [3:0] model_blank(input int n);
        logic b3, b2, b1;
        b3 = (n < 1000);
        b2 = (n < 100);
        b1 = (n < 10);
        return {b3, b2, b1, 1'b0} & BMASK;
    endfunction

    // Sample points are 1 time unit after each rising edge; offset 0 is
    // right after the accepting edge. Returns done offset (-1 on timeout).
    task automatic run_conv(input logic [12:0] n, output logic [15:0] got_bcd,
                            output logic [3:0] got_blank, output int lat,
                            output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        num   = n;
        @(posedge clk); #1;
        start = 1'b0;
        num   = 13'($urandom);
        lat = -1; busy_cycles = 0; got_bcd = 'x; got_blank = 'x;
        for (int c = 0; c <= 40; c++) begin
            if (busy) busy_cycles++;
            if (done) begin
                lat       = c;
                got_bcd   = bcd;
                got_blank = blank;
                check("done_busy_excl", {31'd0, busy}, 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        int          n;
        logic [15:0] eb;
        logic [3:0]  ebl;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] gb;
        logic [3:0]  gbl;
        int          lat, bc, ndone, t1, t2;
        logic [15:0] b1, b2;
        logic [3:0]  l1, l2;
        logic        drop;

        // blank expectations are the mask-on values; BMASK strips them otherwise
        vecs[0] = '{0,    16'h0000, 4'b1110};
        vecs[1] = '{8191, 16'h8191, 4'b0000};
        vecs[2] = '{1,    16'h0001, 4'b1110};
        vecs[3] = '{10,   16'h0010, 4'b1100};
        vecs[4] = '{100,  16'h0100, 4'b1000};
        vecs[5] = '{1000, 16'h1000, 4'b0000};
        vecs[6] = '{4095, 16'h4095, 4'b0000};

        rst = 1'b1; start = 1'b0; num = '0; start4 = 1'b0; num4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_bcd",   {16'd0, bcd}, 32'd0);
        check("rst_blank", {28'd0, blank}, 32'd0);
        check("rst_bcd4",  {16'd0, bcd4}, 32'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_conv(13'(vecs[i].n), gb, gbl, lat, bc);
            check("tbl_latency", lat, 32'd13);
            check("tbl_busy_cycles", bc, 32'd13);
            check("tbl_bcd", {16'd0, gb}, {16'd0, vecs[i].eb});
            check("tbl_blank", {28'd0, gbl}, {28'd0, vecs[i].ebl & BMASK});
        end

        // Randomized against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            int n;
            n = int'($urandom_range(0, 8191));
            run_conv(13'(n), gb, gbl, lat, bc);
            check("rnd_latency", lat, 32'd13);
            check("rnd_bcd", {16'd0, gb}, {16'd0, model_bcd(n)});
            check("rnd_blank", {28'd0, gbl}, {28'd0, model_blank(n)});
        end

        // Start during busy is ignored and num change has no effect
        @(negedge clk);
        start = 1'b1; num = 13'd1234;
        @(posedge clk); #1;
        start = 1'b0; num = 13'd5;
        ndone = 0; t1 = -1; b1 = 'x;
        for (int c = 0; c < 40; c++) begin
            if (c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin t1 = c; b1 = bcd; end
            end
            @(posedge clk); #1;
        end
        check("ign_done_count", ndone, 32'd1);
        check("ign_latency", t1, 32'd13);
        check("ign_bcd", {16'd0, b1}, 32'h1234);

        // Start held high: back-to-back conversions
        @(negedge clk);
        start = 1'b1; num = 13'd50;
        @(posedge clk); #1;
        num = 13'd9;
        ndone = 0; t1 = -1; t2 = -1; drop = 1'b0;
        b1 = 'x; b2 = 'x; l1 = 'x; l2 = 'x;
        for (int c = 0; c < 60; c++) begin
            if (drop) begin start = 1'b0; drop = 1'b0; end
            if (done) begin
                ndone++;
                if (ndone == 1) begin t1 = c; b1 = bcd; l1 = blank; drop = 1'b1; end
                if (ndone == 2) begin t2 = c; b2 = bcd; l2 = blank; end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 32'd2);
        check("b2b_spacing", t2 - t1, 32'd14);
        check("b2b_bcd1", {16'd0, b1}, 32'h0050);
        check("b2b_blank1", {28'd0, l1}, {28'd0, 4'b1100 & BMASK});
        check("b2b_bcd2", {16'd0, b2}, 32'h0009);
        check("b2b_blank2", {28'd0, l2}, {28'd0, 4'b1110 & BMASK});

        // Reset during SHIFT aborts
        @(negedge clk);
        start = 1'b1; num = 13'd4321;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd", {16'd0, bcd}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check("abort_no_done", ndone, 32'd0);
        run_conv(13'd77, gb, gbl, lat, bc);
        check("post_abort_bcd", {16'd0, gb}, 32'h0077);
        check("post_abort_blank", {28'd0, gbl}, {28'd0, 4'b1100 & BMASK});

        // WIDTH=4 instance, every input value
        for (int v = 15; v >= 0; v--) begin
            @(negedge clk);
            start4 = 1'b1; num4 = 4'(v);
            @(posedge clk); #1;
            start4 = 1'b0; num4 = 4'($urandom);
            lat = -1; gb = 'x; gbl = 'x;
            for (int c = 0; c <= 20; c++) begin
                if (done4) begin lat = c; gb = bcd4; gbl = blank4; break; end
                @(posedge clk); #1;
            end
            check("w4_latency", lat, 32'd4);
            check("w4_bcd", {16'd0, gb}, {16'd0, model_bcd(v)});
            check("w4_blank", {28'd0, gbl}, {28'd0, model_blank(v)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
